// File: rtl/ctrl_unit_pkg.sv
// ctrl_unit_pkg: shared types and constants for the ctrl_unit_gen2 controller.
//   state_t     - controller state encoding (also driven on state_o)
//   op_class_t  - instruction class produced by decode_class()
//   FN_* / MEM_* - misc and memory function-field encodings
package ctrl_unit_pkg;

  localparam int unsigned OP_W     = 7;
  localparam int unsigned FUNC_W   = 3;
  localparam int unsigned ALU_OP_W = 4;
  localparam int unsigned IRQ_ID_W = 3;

  typedef enum logic [2:0] {
    FETCH     = 3'd0,
    DECODE    = 3'd1,
    EXECUTE   = 3'd2,
    INT       = 3'd3,
    MEM       = 3'd4,
    WRITEBACK = 3'd5,
    WAIT      = 3'd6,
    ERR       = 3'd7
  } state_t;

  typedef enum logic [2:0] {
    CLS_ALU_IMM,
    CLS_SHIFT,
    CLS_ALU_REG,
    CLS_JUMP,
    CLS_BRANCH,
    CLS_MISC,
    CLS_MEM,
    CLS_ILLEGAL
  } op_class_t;

  // misc function field
  localparam logic [FUNC_W-1:0] FN_WAIT = 3'b100;
  localparam logic [FUNC_W-1:0] FN_STBY = 3'b101;
  localparam logic [FUNC_W-1:0] FN_RETI = 3'b110;

  // memory function field bits [2:1]: bit 2 selects port space, bit 1 is write
  localparam logic [1:0] MEM_LDM = 2'b00;
  localparam logic [1:0] MEM_STM = 2'b01;
  localparam logic [1:0] MEM_INP = 2'b10;
  localparam logic [1:0] MEM_OUT = 2'b11;

  // Classify an opcode by its leading-ones prefix.
  function automatic op_class_t decode_class(input logic [OP_W-1:0] op);
    op_class_t cls;
    cls = CLS_ILLEGAL;
    if (!op[6])                       cls = CLS_ALU_IMM;
    else if (op[6:5] == 2'b10)        cls = CLS_MEM;
    else if (op[6:4] == 3'b110)       cls = CLS_SHIFT;
    else if (op[6:3] == 4'b1110)      cls = CLS_ALU_REG;
    else if (op[6:2] == 5'b11110)     cls = CLS_JUMP;
    else if (op[6:1] == 6'b111110)    cls = CLS_BRANCH;
    else if (op == 7'b1111110)        cls = CLS_MISC;
    return cls;
  endfunction

  // ALU operation select for a given class/function pair.
  function automatic logic [ALU_OP_W-1:0] alu_op_of(input op_class_t cls,
                                                     input logic [FUNC_W-1:0] func);
    logic [ALU_OP_W-1:0] res;
    res = '0;
    case (cls)
      CLS_ALU_IMM, CLS_ALU_REG:
        if (func != 3'b011 && func != 3'b100) res = {1'b0, func};
      CLS_SHIFT: res = {2'b10, func[1:0]};
      default:   res = '0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// irq_prio_enc: fixed-priority interrupt encoder, lowest index wins.
//   pend   - pending (already masked/enabled) request lines
//   onehot - one-hot winner, zero when nothing pending
//   idx    - winner index, zero when nothing pending
module irq_prio_enc
  import ctrl_unit_pkg::*;
#(
  parameter int unsigned NUM_IRQ = 4
) (
  input  logic [NUM_IRQ-1:0]  pend,
  output logic [NUM_IRQ-1:0]  onehot,
  output logic [IRQ_ID_W-1:0] idx
);

  // Scan from the top down so the last hit (lowest index) is kept.
  always_comb begin
    onehot = '0;
    idx    = '0;
    for (int i = int'(NUM_IRQ) - 1; i >= 0; i--) begin
      if (pend[i]) begin
        onehot    = '0;
        onehot[i] = 1'b1;
        idx       = IRQ_ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/ctrl_unit_gen2.sv
// ctrl_unit_gen2: multi-cycle instruction controller with bus timeouts and
// prioritised interrupts.
//   clk, rst                 - clock, synchronous active-high reset
//   irq_i, irq_mask_i        - level interrupt requests and per-line masks
//   inst/data/port_ack_i     - bus acknowledges
//   op_i, func_i             - instruction fields, captured with inst_ack_i
//   stb_o, cyc_o             - instruction bus controls (FETCH)
//   data_*/port_* outputs    - data and port bus controls (EXECUTE/MEM)
//   alu_op_o, alu_en_o, reg_wr_o, pc_en_o, reti_o, sleep_o, bus_err_o
//   int_ack_o, int_id_o      - interrupt acknowledge and serviced index
//   state_o                  - current state
module ctrl_unit_gen2
  import ctrl_unit_pkg::*;
#(
  parameter int unsigned NUM_IRQ    = 4,
  parameter int unsigned TMO_CYCLES = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_IRQ-1:0]  irq_i,
  input  logic [NUM_IRQ-1:0]  irq_mask_i,
  input  logic                inst_ack_i,
  input  logic                data_ack_i,
  input  logic                port_ack_i,
  input  logic [OP_W-1:0]     op_i,
  input  logic [FUNC_W-1:0]   func_i,
  output logic                stb_o,
  output logic                cyc_o,
  output logic                data_stb_o,
  output logic                data_cyc_o,
  output logic                data_we_o,
  output logic                port_stb_o,
  output logic                port_we_o,
  output logic [ALU_OP_W-1:0] alu_op_o,
  output logic                alu_en_o,
  output logic                reg_wr_o,
  output logic                pc_en_o,
  output logic                reti_o,
  output logic                sleep_o,
  output logic                bus_err_o,
  output logic [NUM_IRQ-1:0]  int_ack_o,
  output logic [IRQ_ID_W-1:0] int_id_o,
  output logic [2:0]          state_o
);

  localparam int unsigned CNT_W = (TMO_CYCLES > 2) ? $clog2(TMO_CYCLES) : 1;

  state_t                 state, state_nxt;
  logic [OP_W-1:0]        op_q;
  logic [FUNC_W-1:0]      func_q;
  op_class_t              cls_q;
  logic                   ie;
  logic [CNT_W-1:0]       cnt;
  logic [NUM_IRQ-1:0]     pend;
  logic                   pend_any;
  logic [NUM_IRQ-1:0]     win_onehot;
  logic [IRQ_ID_W-1:0]    win_id;
  logic                   tmo;
  logic                   is_mem;
  logic                   mem_ack;
  state_t                 mem_done_st;
  state_t                 ret_st;
  logic                   reti_in;
  logic                   bus_phase;

  assign pend     = irq_i & ~irq_mask_i & {NUM_IRQ{ie}};
  assign pend_any = |pend;

  irq_prio_enc #(.NUM_IRQ(NUM_IRQ)) u_prio (
    .pend   (pend),
    .onehot (win_onehot),
    .idx    (win_id)
  );

  assign cls_q   = decode_class(op_q);
  assign is_mem  = (cls_q == CLS_MEM);
  assign tmo     = (cnt == CNT_W'(TMO_CYCLES - 1));
  // func[2] selects port space, func[1] marks a write
  assign mem_ack = func_q[2] ? port_ack_i : data_ack_i;
  assign ret_st  = pend_any ? INT : FETCH;
  // loads return data to a register, stores complete directly
  assign mem_done_st = func_q[1] ? ret_st : WRITEBACK;
  // reti is recognised as the instruction arrives so reti_o lines up with DECODE
  assign reti_in = (decode_class(op_i) == CLS_MISC) && (func_i == FN_RETI);

  // The only Mealy output: advance the PC on the fetch acknowledge itself.
  assign pc_en_o = !rst && (state == FETCH) && inst_ack_i;
  assign state_o = state;

  // Next-state selection.
  always_comb begin
    state_nxt = state;
    case (state)
      FETCH: begin
        if (inst_ack_i) state_nxt = DECODE;
        else if (tmo)   state_nxt = ERR;
      end
      DECODE: begin
        case (cls_q)
          CLS_ILLEGAL: state_nxt = ERR;
          CLS_MISC: begin
            if (func_q == FN_WAIT || func_q == FN_STBY) state_nxt = WAIT;
            else                                        state_nxt = ret_st;
          end
          CLS_JUMP, CLS_BRANCH: state_nxt = ret_st;
          default:              state_nxt = EXECUTE;
        endcase
      end
      EXECUTE: begin
        if (!is_mem)      state_nxt = WRITEBACK;
        else if (mem_ack) state_nxt = mem_done_st;
        else              state_nxt = MEM;
      end
      MEM: begin
        if (mem_ack)  state_nxt = mem_done_st;
        else if (tmo) state_nxt = ERR;
      end
      WRITEBACK: state_nxt = ret_st;
      INT:       state_nxt = FETCH;
      WAIT:      if (pend_any) state_nxt = INT;
      ERR:       state_nxt = FETCH;
      default:   state_nxt = FETCH;
    endcase
  end

  assign bus_phase = ((state_nxt == EXECUTE) || (state_nxt == MEM)) && is_mem;

  // State, bookkeeping and registered Moore outputs for the state being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= FETCH;
      ie         <= 1'b1;
      cnt        <= '0;
      op_q       <= '0;
      func_q     <= '0;
      int_id_o   <= '0;
      stb_o      <= 1'b1;
      cyc_o      <= 1'b1;
      data_stb_o <= 1'b0;
      data_cyc_o <= 1'b0;
      data_we_o  <= 1'b0;
      port_stb_o <= 1'b0;
      port_we_o  <= 1'b0;
      alu_op_o   <= '0;
      alu_en_o   <= 1'b0;
      reg_wr_o   <= 1'b0;
      reti_o     <= 1'b0;
      sleep_o    <= 1'b0;
      bus_err_o  <= 1'b0;
      int_ack_o  <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= (state_nxt != state) ? '0 : cnt + CNT_W'(1);

      if (state == FETCH && inst_ack_i) begin
        op_q   <= op_i;
        func_q <= func_i;
      end

      if (state_nxt == INT) begin
        ie       <= 1'b0;
        int_id_o <= win_id;
      end else if (state == FETCH && state_nxt == DECODE && reti_in) begin
        ie <= 1'b1;
      end

      stb_o      <= (state_nxt == FETCH);
      cyc_o      <= (state_nxt == FETCH);
      data_stb_o <= bus_phase && !func_q[2];
      data_cyc_o <= bus_phase && !func_q[2];
      data_we_o  <= bus_phase && !func_q[2] && func_q[1];
      port_stb_o <= bus_phase && func_q[2];
      port_we_o  <= bus_phase && func_q[2] && func_q[1];
      alu_op_o   <= (state_nxt == EXECUTE || state_nxt == WRITEBACK)
                    ? alu_op_of(cls_q, func_q) : '0;
      alu_en_o   <= (state_nxt == EXECUTE) && !is_mem;
      reg_wr_o   <= (state_nxt == WRITEBACK);
      reti_o     <= (state == FETCH) && (state_nxt == DECODE) && reti_in;
      sleep_o    <= (state_nxt == WAIT);
      bus_err_o  <= (state_nxt == ERR);
      int_ack_o  <= (state_nxt == INT) ? win_onehot : '0;
    end
  end

endmodule

// File: tb/tb_ctrl_unit_gen2.sv
// tb_ctrl_unit_gen2: scenario-driven bench for ctrl_unit_gen2. Each cycle's
// expected outputs are queued as stimulus is applied and compared against the
// captured outputs at the end of each scenario.
module tb_ctrl_unit_gen2;

  localparam int unsigned N = 4;

  localparam logic [2:0] S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXECUTE = 3'd2,
                         S_INT = 3'd3, S_MEM = 3'd4, S_WB = 3'd5,
                         S_WAIT = 3'd6, S_ERR = 3'd7;

  localparam logic [6:0] OP_ALU_IMM = 7'b0000000, OP_SHIFT = 7'b1100000,
                         OP_ALU_REG = 7'b1110000, OP_BRANCH = 7'b1111100,
                         OP_MISC = 7'b1111110, OP_MEM = 7'b1000000,
                         OP_ILL = 7'b1111111;

  typedef struct packed {
    logic [2:0] st;
    logic       stb, cyc, dstb, dcyc, dwe, pstb, pwe;
    logic [3:0] aluop;
    logic       aluen, regwr, pcen, reti, sleep, berr;
    logic [N-1:0] iack;
    logic [2:0] iid;
  } obs_t;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] irq, mask;
  logic         iack_in, dack, pack;
  logic [6:0]   op;
  logic [2:0]   func;

  logic         stb_o, cyc_o, data_stb_o, data_cyc_o, data_we_o, port_stb_o, port_we_o;
  logic [3:0]   alu_op_o;
  logic         alu_en_o, reg_wr_o, pc_en_o, reti_o, sleep_o, bus_err_o;
  logic [N-1:0] int_ack_o;
  logic [2:0]   int_id_o, state_o;

  obs_t sb[$];
  obs_t got[$];
  int   errors = 0;
  int   checks = 0;
  logic [2:0] exp_iid = 3'd0;

  always #5 clk = ~clk;

  ctrl_unit_gen2 #(.NUM_IRQ(N), .TMO_CYCLES(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .irq_i      (irq),
    .irq_mask_i (mask),
    .inst_ack_i (iack_in),
    .data_ack_i (dack),
    .port_ack_i (pack),
    .op_i       (op),
    .func_i     (func),
    .stb_o      (stb_o),
    .cyc_o      (cyc_o),
    .data_stb_o (data_stb_o),
    .data_cyc_o (data_cyc_o),
    .data_we_o  (data_we_o),
    .port_stb_o (port_stb_o),
    .port_we_o  (port_we_o),
    .alu_op_o   (alu_op_o),
    .alu_en_o   (alu_en_o),
    .reg_wr_o   (reg_wr_o),
    .pc_en_o    (pc_en_o),
    .reti_o     (reti_o),
    .sleep_o    (sleep_o),
    .bus_err_o  (bus_err_o),
    .int_ack_o  (int_ack_o),
    .int_id_o   (int_id_o),
    .state_o    (state_o)
  );

  // Expected outputs for a plain visit to a state (no data-dependent extras).
  function automatic obs_t base(input logic [2:0] st);
    obs_t e;
    e     = '0;
    e.st  = st;
    e.iid = exp_iid;
    case (st)
      S_FETCH: begin e.stb = 1'b1; e.cyc = 1'b1; end
      S_WB:    e.regwr = 1'b1;
      S_WAIT:  e.sleep = 1'b1;
      S_ERR:   e.berr  = 1'b1;
      default: ;
    endcase
    return e;
  endfunction

  function automatic obs_t observe();
    obs_t o;
    o = '{st: state_o, stb: stb_o, cyc: cyc_o, dstb: data_stb_o, dcyc: data_cyc_o,
          dwe: data_we_o, pstb: port_stb_o, pwe: port_we_o, aluop: alu_op_o,
          aluen: alu_en_o, regwr: reg_wr_o, pcen: pc_en_o, reti: reti_o,
          sleep: sleep_o, berr: bus_err_o, iack: int_ack_o, iid: int_id_o};
    return o;
  endfunction

  // One clock cycle with the inputs currently applied; called just after a negedge.
  task automatic tick(input obs_t e);
    sb.push_back(e);
    #1;
    got.push_back(observe());
    @(negedge clk);
  endtask

  task automatic test_reset();
    obs_t e, g;
    int k;
    rst = 1'b1; iack_in = 1'b1;
    e = base(S_FETCH);
    tick(e);
    tick(e);
    rst = 1'b0; iack_in = 1'b0;
    k = 0;
    while (sb.size() != 0) begin
      e = sb.pop_front(); g = got.pop_front(); checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL reset[%0d]: got=%h expected=%h", k, g, e);
      end
      k++;
    end
  endtask

  task automatic test_alu();
    obs_t e, g;
    int k;
    op = OP_ALU_IMM; func = 3'b001;
    iack_in = 1'b1; e = base(S_FETCH); e.pcen = 1'b1; tick(e);
    iack_in = 1'b0; tick(base(S_DECODE));
    e = base(S_EXECUTE); e.aluen = 1'b1; e.aluop = 4'b0001; tick(e);
    e = base(S_WB); e.aluop = 4'b0001; tick(e);
    k = 0;
    while (sb.size() != 0) begin
      e = sb.pop_front(); g = got.pop_front(); checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL alu[%0d]: got=%h expected=%h", k, g, e);
      end
      k++;
    end
  endtask

  task automatic test_alu_ops();
    obs_t e, g;
    int k;
    logic [6:0] ops [6] = '{OP_ALU_REG, OP_SHIFT, OP_ALU_IMM, OP_ALU_IMM, OP_ALU_IMM, OP_SHIFT};
    logic [2:0] fns [6] = '{3'b110, 3'b111, 3'b011, 3'b100, 3'b101, 3'b000};
    logic [3:0] res [6] = '{4'b0110, 4'b1011, 4'b0000, 4'b0000, 4'b0101, 4'b1000};
    for (int i = 0; i < 6; i++) begin
      op = ops[i]; func = fns[i];
      iack_in = 1'b1; e = base(S_FETCH); e.pcen = 1'b1; tick(e);
      iack_in = 1'b0; tick(base(S_DECODE));
      e = base(S_EXECUTE); e.aluen = 1'b1; e.aluop = res[i]; tick(e);
      e = base(S_WB); e.aluop = res[i]; tick(e);
    end
    k = 0;
    while (sb.size() != 0) begin
      e = sb.pop_front(); g = got.pop_front(); checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL alu_ops[%0d]: got=%h expected=%h", k, g, e);
      end
      k++;
    end
  endtask

  task automatic test_mem_irq();
    obs_t e, g;
    int k;
    irq = 4'b0100; mask = 4'b0000;
    op = OP_MEM; func = 3'b010;
    iack_in = 1'b1; e = base(S_FETCH); e.pcen = 1'b1; tick(e);
    iack_in = 1'b0; tick(base(S_DECODE));
    e = base(S_EXECUTE); e.dstb = 1'b1; e.dcyc = 1'b1; e.dwe = 1'b1; tick(e);
    e.st = S_MEM; tick(e);
    tick(e);
    dack = 1'b1; tick(e);
    dack = 1'b0;
    exp_iid = 3'd2;
    e = base(S_INT); e.iack = 4'b0100; tick(e);
    // interrupts now disabled: a branch with the line still high returns to FETCH
    op = OP_BRANCH; func = 3'b000;
    iack_in = 1'b1; e = base(S_FETCH); e.pcen = 1'b1; tick(e);
    iack_in = 1'b0; tick(base(S_DECODE));
    k = 0;
    while (sb.size() != 0) begin
      e = sb.pop_front(); g = got.pop_front(); checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL mem_irq[%0d]: got=%h expected=%h", k, g, e);
      end
      k++;
    end
  endtask

  task automatic test_reti_illegal();
    obs_t e, g;
    int k;
    irq = 4'b1000;
    op = OP_MISC; func = 3'b110;
    iack_in = 1'b1; e = base(S_FETCH); e.pcen = 1'b1; tick(e);
    iack_in = 1'b0; e = base(S_DECODE); e.reti = 1'b1; tick(e);
    exp_iid = 3'd3;
    e = base(S_INT); e.iack = 4'b1000; tick(e);
    irq = 4'b0000;
    op = OP_ILL; func = 3'b000;
    iack_in = 1'b1; e = base(S_FETCH); e.pcen = 1'b1; tick(e);
    iack_in = 1'b0; tick(base(S_DECODE));
    tick(base(S_ERR));
    k = 0;
    while (sb.size() != 0) begin
      e = sb.pop_front(); g = got.pop_front(); checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL reti_illegal[%0d]: got=%h expected=%h", k, g, e);
      end
      k++;
    end
  endtask

  task automatic test_wait();
    obs_t e, g;
    int k;
    irq = 4'b0000; mask = 4'b0000;
    op = OP_MISC; func = 3'b110;
    iack_in = 1'b1; e = base(S_FETCH); e.pcen = 1'b1; tick(e);
    iack_in = 1'b0; e = base(S_DECODE); e.reti = 1'b1; tick(e);
    // masked line alone must not wake the controller
    irq = 4'b0001; mask = 4'b0001;
    op = OP_MISC; func = 3'b100;
    iack_in = 1'b1; e = base(S_FETCH); e.pcen = 1'b1; tick(e);
    iack_in = 1'b0; tick(base(S_DECODE));
    for (int i = 0; i < 3; i++) tick(base(S_WAIT));
    irq = 4'b0011;
    tick(base(S_WAIT));
    exp_iid = 3'd1;
    e = base(S_INT); e.iack = 4'b0010; tick(e);
    irq = 4'b0000; mask = 4'b0000;
    k = 0;
    while (sb.size() != 0) begin
      e = sb.pop_front(); g = got.pop_front(); checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL wait[%0d]: got=%h expected=%h", k, g, e);
      end
      k++;
    end
  endtask

  task automatic test_timeout();
    obs_t e, g;
    int k;
    iack_in = 1'b0;
    for (int i = 0; i < 16; i++) tick(base(S_FETCH));
    tick(base(S_ERR));
    // acknowledge on the last allowed cycle wins over the timeout
    op = OP_BRANCH; func = 3'b000;
    for (int i = 0; i < 15; i++) tick(base(S_FETCH));
    iack_in = 1'b1; e = base(S_FETCH); e.pcen = 1'b1; tick(e);
    iack_in = 1'b0; tick(base(S_DECODE));
    // store that never gets acknowledged
    op = OP_MEM; func = 3'b010;
    iack_in = 1'b1; e = base(S_FETCH); e.pcen = 1'b1; tick(e);
    iack_in = 1'b0; tick(base(S_DECODE));
    e = base(S_EXECUTE); e.dstb = 1'b1; e.dcyc = 1'b1; e.dwe = 1'b1; tick(e);
    e.st = S_MEM;
    for (int i = 0; i < 16; i++) tick(e);
    tick(base(S_ERR));
    k = 0;
    while (sb.size() != 0) begin
      e = sb.pop_front(); g = got.pop_front(); checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL timeout[%0d]: got=%h expected=%h", k, g, e);
      end
      k++;
    end
  endtask

  task automatic test_back_to_back();
    obs_t e, g;
    int k;
    op = OP_MEM;
    func = 3'b100;  // inp, acknowledged immediately
    iack_in = 1'b1; e = base(S_FETCH); e.pcen = 1'b1; tick(e);
    iack_in = 1'b0; tick(base(S_DECODE));
    pack = 1'b1; e = base(S_EXECUTE); e.pstb = 1'b1; tick(e);
    pack = 1'b0; tick(base(S_WB));
    func = 3'b110;  // out, stray data ack ignored, port ack in MEM
    iack_in = 1'b1; e = base(S_FETCH); e.pcen = 1'b1; tick(e);
    iack_in = 1'b0; tick(base(S_DECODE));
    dack = 1'b1; e = base(S_EXECUTE); e.pstb = 1'b1; e.pwe = 1'b1; tick(e);
    dack = 1'b0; pack = 1'b1; e.st = S_MEM; tick(e);
    pack = 1'b0;
    func = 3'b000;  // ldm, acknowledged immediately
    iack_in = 1'b1; e = base(S_FETCH); e.pcen = 1'b1; tick(e);
    iack_in = 1'b0; tick(base(S_DECODE));
    dack = 1'b1; e = base(S_EXECUTE); e.dstb = 1'b1; e.dcyc = 1'b1; tick(e);
    dack = 1'b0; tick(base(S_WB));
    k = 0;
    while (sb.size() != 0) begin
      e = sb.pop_front(); g = got.pop_front(); checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL back_to_back[%0d]: got=%h expected=%h", k, g, e);
      end
      k++;
    end
  endtask

  task automatic test_reset_mid();
    obs_t e, g;
    int k;
    op = OP_MEM; func = 3'b000;
    iack_in = 1'b1; e = base(S_FETCH); e.pcen = 1'b1; tick(e);
    iack_in = 1'b0; tick(base(S_DECODE));
    e = base(S_EXECUTE); e.dstb = 1'b1; e.dcyc = 1'b1; tick(e);
    e.st = S_MEM; tick(e);
    rst = 1'b1; tick(e);
    rst = 1'b0;
    exp_iid = 3'd0;
    tick(base(S_FETCH));
    tick(base(S_FETCH));
    k = 0;
    while (sb.size() != 0) begin
      e = sb.pop_front(); g = got.pop_front(); checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL reset_mid[%0d]: got=%h expected=%h", k, g, e);
      end
      k++;
    end
  endtask

  initial begin
    rst = 1'b1; irq = '0; mask = '0; iack_in = 1'b0; dack = 1'b0; pack = 1'b0;
    op = '0; func = '0;
    @(negedge clk);
    test_reset();
    test_alu();
    test_alu_ops();
    test_mem_irq();
    test_reti_illegal();
    test_wait();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
